collision_frame: RTL
====================

# collision_frame

- Parametrised, frame-based successor to the per-pixel ball/pipe collision flag.
- Accumulates ball-vs-object pixel overlap per object channel across one video frame.
- At each frame boundary, applies a minimum-overlap threshold and latches a per-channel hit mask. A sticky game-over is held until the game FSM acknowledges it.
- Sits between the sprite/pipe pixel generators and the game-control FSM.

## Interface

Parameters:
- N_OBJ, 4, number of object channels (pipe body, pipe edge, ground, ceiling, ...)
- CNT_W, 10, width of each per-channel overlap counter
- THRESH, 4, minimum overlap pixels in one frame to register a hit; legal range 1 .. 2^CNT_W-1

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame strobe, synchronous to Clk; its rising edge marks the frame boundary
- enable  in  1  arms detection; low forces IDLE
- pixel_valid  in  1  current is_* inputs describe a visible pixel
- is_ball  in  1  current pixel belongs to the ball
- is_obj  in  N_OBJ  current pixel belongs to object channel i
- ack  in  1  clears a latched game-over
- hit  out  1  one-cycle pulse when a frame closes with any channel at or above THRESH
- hit_mask  out  N_OBJ  channels that met THRESH in the last evaluated frame
- game_over  out  1  sticky collision flag
- armed  out  1  high in ARMED state

## Operation

- FSM states: IDLE, ARMED, LATCHED.
- Frame edge: fe = frame_clk & ~frame_clk_q, where frame_clk_q is a registered copy of frame_clk.
- IDLE:
  - counters held at 0.
  - enable=1 and fe -> ARMED. Counting starts on the cycle after the edge.
- ARMED:
  - Each cycle with pixel_valid & is_ball & is_obj[i], cnt[i] increments.
  - cnt[i] saturates at 2^CNT_W-1; no wrap.
- On fe in ARMED:
  - hit_mask[i] <= (cnt[i] >= THRESH) for every i.
  - All cnt cleared.
  - Any bit set -> hit pulse, game_over <= 1, go to LATCHED.
  - Otherwise stay ARMED; hit_mask is still updated, to all zero.
- enable=0 in ARMED -> IDLE with counters cleared; hit_mask is not updated.
- LATCHED:
  - counters held at 0; hit_mask and game_over held.
  - ack=1 -> IDLE, game_over <= 0, hit_mask <= 0.
- Simultaneous events:
  - fe and an overlap pixel in the same cycle: that pixel is discarded. Evaluation uses counts through the previous cycle.
  - ack and fe together in LATCHED: ack wins, go to IDLE, the edge is ignored. Re-arm needs the next fe.
  - enable=0 and fe together in ARMED: enable wins, no evaluation.
  - ack outside LATCHED: no effect.
- Channels are independent. Multiple is_obj bits high on one pixel increment every matching counter.

## Timing

- Reset values:
  - state IDLE; all cnt 0; frame_clk_q 1, so a frame_clk already high at reset release produces no edge.
  - hit 0, hit_mask 0, game_over 0, armed 0.
- Reset mid-frame or while LATCHED: everything returns to reset values immediately (asynchronous).
- Registered outputs:
  - hit, hit_mask and game_over change at the Clk edge that ends the fe cycle, i.e. one cycle of latency from frame_clk rising.
  - hit is high for exactly one cycle.
- armed is a registered state decode; it rises one cycle after the arming fe.
- Overlap counting has no latency beyond the register: the pixel in cycle k is reflected in cnt at cycle k+1.

## Structure

- Package collision_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, LATCHED} coll_state_t;
  - default parameter constants COLL_N_OBJ, COLL_CNT_W, COLL_THRESH.
- Sub-module overlap_counter (CNT_W, THRESH): saturating counter with inc/clr inputs and a ge_thresh output. It is instantiated N_OBJ times through a generate loop.
- The FSM, edge detector and output registers stay in collision_frame.

## Test plan

All scenarios use N_OBJ=2, CNT_W=4, THRESH=4.

- Reset with frame_clk held high; release reset -> no hit, state IDLE, armed=0 for 10 cycles.
- enable=1, fe, then 3 overlap pixels on ch0, then fe -> hit=0, hit_mask=00, still ARMED. Repeat with 4 pixels -> hit pulses 1 cycle, hit_mask=01, game_over=1.
- 20 overlap pixels on ch1 -> cnt saturates at 15 without wrapping; at fe, hit_mask=10.
- Overlap pixel asserted in the same cycle as fe, after 3 prior pixels on ch0 -> hit_mask=00, and the next frame's count starts at 0.
- In LATCHED, apply ack and fe together -> IDLE, game_over=0, hit_mask=00; re-armed only at the following fe.
- Async Reset pulse mid-frame with cnt[0]=3 -> outputs 0 at once; after re-arm, 1 further pixel plus fe gives no hit.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and default parameters for the frame-based ball/object collision detector.
package collision_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, LATCHED} coll_state_t;

    localparam int unsigned COLL_N_OBJ  = 4;
    localparam int unsigned COLL_CNT_W  = 10;
    localparam int unsigned COLL_THRESH = 4;

endpackage

// File: rtl/collision_frame_if.sv
// Pixel-side stimulus and game-FSM-side results of collision_frame, bundled as one interface.
interface collision_frame_if import collision_pkg::*; #(
    parameter int unsigned N_OBJ = COLL_N_OBJ
);
    logic             frame_clk;
    logic             enable;
    logic             pixel_valid;
    logic             is_ball;
    logic [N_OBJ-1:0] is_obj;
    logic             ack;
    logic             hit;
    logic [N_OBJ-1:0] hit_mask;
    logic             game_over;
    logic             armed;

    modport master (
        output frame_clk, enable, pixel_valid, is_ball, is_obj, ack,
        input  hit, hit_mask, game_over, armed
    );

    modport slave (
        input  frame_clk, enable, pixel_valid, is_ball, is_obj, ack,
        output hit, hit_mask, game_over, armed
    );
endinterface

// File: rtl/overlap_counter.sv
// Per-channel saturating overlap counter; clear dominates increment.
module overlap_counter #(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_ge_thresh_c
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_ge_thresh_c = (r_cnt >= CNT_THR);

endmodule

// File: rtl/collision_frame.sv
// Frame-based collision detector: counts ball/object overlap per channel and latches a hit
// mask and sticky game-over at each frame boundary.
module collision_frame import collision_pkg::*; #(
    parameter int unsigned N_OBJ  = COLL_N_OBJ,
    parameter int unsigned CNT_W  = COLL_CNT_W,
    parameter int unsigned THRESH = COLL_THRESH
) (
    input logic              Clk,
    input logic              Reset,
    collision_frame_if.slave bus
);
    coll_state_t      r_state;
    logic             r_frame_clk_q;
    logic             r_hit;
    logic             r_game_over;
    logic             r_armed;
    logic [N_OBJ-1:0] r_hit_mask;

    logic             w_fe;
    logic             w_clr;
    logic [N_OBJ-1:0] w_inc;
    logic [N_OBJ-1:0] w_ge;

    // A pixel coinciding with the frame edge is dropped: clear wins over increment.
    assign w_fe  = bus.frame_clk & ~r_frame_clk_q;
    assign w_clr = (r_state != ARMED) | ~bus.enable | w_fe;
    assign w_inc = {N_OBJ{bus.pixel_valid & bus.is_ball}} & bus.is_obj;

    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_ch
        overlap_counter #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_cnt (
            .clk           (Clk),
            .rst           (Reset),
            .i_inc         (w_inc[gi]),
            .i_clr         (w_clr),
            .o_ge_thresh_c (w_ge[gi])
        );
    end

    // frame_clk_q resets high so a strobe already high at release is not seen as an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_frame_clk_q <= 1'b1;
            r_hit         <= 1'b0;
            r_hit_mask    <= '0;
            r_game_over   <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_frame_clk_q <= bus.frame_clk;
            r_hit         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable && w_fe) begin
                        r_state <= ARMED;
                        r_armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!bus.enable) begin
                        r_state <= IDLE;
                        r_armed <= 1'b0;
                    end else if (w_fe) begin
                        r_hit_mask <= w_ge;
                        if (|w_ge) begin
                            r_hit       <= 1'b1;
                            r_game_over <= 1'b1;
                            r_state     <= LATCHED;
                            r_armed     <= 1'b0;
                        end
                    end
                end
                LATCHED: begin
                    if (bus.ack) begin
                        r_state     <= IDLE;
                        r_game_over <= 1'b0;
                        r_hit_mask  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hit       = r_hit;
    assign bus.hit_mask  = r_hit_mask;
    assign bus.game_over = r_game_over;
    assign bus.armed     = r_armed;

endmodule
